// File: rtl/pwm_sequencer.sv
// Table-driven sequencer for the 8-bit PWM core: steps through stored {period, pulse, size, repeat}
// settings one PWM period at a time, switching only on period boundaries, using a mirror counter.
module pwm_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [31:0]   cfg_period,
    input  logic [31:0]   cfg_pulse,
    input  logic [7:0]    cfg_size,
    input  logic [15:0]   cfg_repeat,
    input  logic [AW-1:0] last_idx,
    input  logic          loop,
    input  logic          start,
    input  logic          stop,
    output logic [31:0]   period,
    output logic [31:0]   pulse,
    output logic [31:0]   size,
    output logic [31:0]   enable,
    output logic          busy,
    output logic [AW-1:0] idx,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST_MAX = AW'(DEPTH - 1);

    state_t        state;
    logic [31:0]   tbl_period [DEPTH];
    logic [31:0]   tbl_pulse  [DEPTH];
    logic [7:0]    tbl_size   [DEPTH];
    logic [15:0]   tbl_repeat [DEPTH];

    logic [31:0]   period_r;
    logic [31:0]   pulse_r;
    logic [7:0]    size_r;
    logic [15:0]   rep_lim;
    logic          en_r;
    logic          busy_r;
    logic          done_r;
    logic [AW-1:0] idx_r;
    logic [31:0]   cnt;
    logic [15:0]   rep;

    logic [AW-1:0] last_eff;
    logic [AW-1:0] ld_idx;
    logic          period_end;
    logic          entry_last;
    logic          do_load;
    logic          do_finish;

    // Load/finish decisions for this cycle; the FSM below only applies them.
    always_comb begin
        last_eff   = (32'(last_idx) >= 32'(DEPTH)) ? LAST_MAX : last_idx;
        period_end = (state != IDLE) && (cnt == period_r);
        entry_last = (rep == rep_lim);
        ld_idx     = '0;
        if (state != IDLE && idx_r != last_eff)
            ld_idx = (idx_r == LAST_MAX) ? '0 : idx_r + AW'(1);
        do_finish  = period_end &&
                     ((state == DRAIN) || stop || (entry_last && idx_r == last_eff && !loop));
        do_load    = ((state == IDLE) && start) ||
                     ((state == RUN) && period_end && entry_last && !do_finish);
    end

    // Table storage; a load in the same cycle as a write sees the old contents.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_period[i] <= '0;
                tbl_pulse[i]  <= '0;
                tbl_size[i]   <= '0;
                tbl_repeat[i] <= '0;
            end
        end else if (cfg_we && (32'(cfg_addr) < 32'(DEPTH))) begin
            tbl_period[cfg_addr] <= cfg_period;
            tbl_pulse[cfg_addr]  <= cfg_pulse;
            tbl_size[cfg_addr]   <= cfg_size;
            tbl_repeat[cfg_addr] <= cfg_repeat;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state    <= IDLE;
            period_r <= '0;
            pulse_r  <= '0;
            size_r   <= '0;
            rep_lim  <= '0;
            en_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            idx_r    <= '0;
            cnt      <= '0;
            rep      <= '0;
        end else begin
            done_r <= 1'b0;
            if (state != IDLE)
                cnt <= period_end ? '0 : cnt + 32'd1;

            if (do_load) begin
                period_r <= tbl_period[ld_idx];
                pulse_r  <= tbl_pulse[ld_idx];
                size_r   <= tbl_size[ld_idx];
                rep_lim  <= tbl_repeat[ld_idx];
                idx_r    <= ld_idx;
                rep      <= '0;
            end else if (period_end && state == RUN && !stop) begin
                rep <= rep + 16'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        en_r   <= 1'b1;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN, DRAIN: begin
                    if (do_finish) begin
                        en_r   <= 1'b0;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        rep    <= '0;
                        state  <= IDLE;
                    end else if (stop) begin
                        state <= DRAIN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign period = period_r;
    assign pulse  = pulse_r;
    assign size   = {24'd0, size_r};
    assign enable = {31'd0, en_r};
    assign busy   = busy_r;
    assign idx    = idx_r;
    assign done   = done_r;

endmodule

// File: tb/tb_pwm_sequencer.sv
// Scoreboard bench for pwm_sequencer: directed sequences push per-cycle expectations,
// a monitor compares every cycle the sequencer is active or signalling done.
`timescale 1ns/1ps
module tb_pwm_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          PCLK = 1'b0;
    logic          PRESETn = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [31:0]   cfg_period = '0;
    logic [31:0]   cfg_pulse = '0;
    logic [7:0]    cfg_size = '0;
    logic [15:0]   cfg_repeat = '0;
    logic [AW-1:0] last_idx = '0;
    logic          loop = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [31:0]   period;
    logic [31:0]   pulse;
    logic [31:0]   size;
    logic [31:0]   enable;
    logic          busy;
    logic [AW-1:0] idx;
    logic          done;

    pwm_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_period(cfg_period),
        .cfg_pulse(cfg_pulse), .cfg_size(cfg_size), .cfg_repeat(cfg_repeat),
        .last_idx(last_idx), .loop(loop), .start(start), .stop(stop),
        .period(period), .pulse(pulse), .size(size), .enable(enable),
        .busy(busy), .idx(idx), .done(done)
    );

    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic [31:0]   en;
        logic          busy;
        logic          done;
        logic [AW-1:0] idx;
        logic [31:0]   per;
        logic [31:0]   pul;
        logic [31:0]   sz;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   tcyc = 0;
    int   nrec = 0;

    task automatic push(input logic [AW-1:0] i, input logic [31:0] p, input logic [31:0] pu,
                        input logic [7:0] s, input int n);
        for (int k = 0; k < n; k++)
            exp_q.push_back('{en: 32'd1, busy: 1'b1, done: 1'b0, idx: i, per: p, pul: pu, sz: {24'd0, s}});
    endtask

    task automatic push_done(input logic [AW-1:0] i, input logic [31:0] p, input logic [31:0] pu,
                             input logic [7:0] s);
        exp_q.push_back('{en: 32'd0, busy: 1'b0, done: 1'b1, idx: i, per: p, pul: pu, sz: {24'd0, s}});
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_period"}, period, 32'd0);
        chk({nm, "_pulse"}, pulse, 32'd0);
        chk({nm, "_size"}, size, 32'd0);
        chk({nm, "_enable"}, enable, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_idx"}, {30'd0, idx}, 32'd0);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
    endtask

    task automatic monitor();
        rec_t got;
        rec_t e;
        forever begin
            @(negedge PCLK);
            if (PRESETn && (busy || enable[0] || done)) begin
                got = '{en: enable, busy: busy, done: done, idx: idx, per: period, pul: pulse, sz: size};
                checks++;
                nrec++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_%0d unexpected output en=%0h busy=%0b done=%0b idx=%0d per=%0h pul=%0h sz=%0h required none",
                             nrec, got.en, got.busy, got.done, got.idx, got.per, got.pul, got.sz);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        errors++;
                        $display("FAIL out_%0d got en=%0h busy=%0b done=%0b idx=%0d per=%0h pul=%0h sz=%0h required en=%0h busy=%0b done=%0b idx=%0d per=%0h pul=%0h sz=%0h",
                                 nrec, got.en, got.busy, got.done, got.idx, got.per, got.pul, got.sz,
                                 e.en, e.busy, e.done, e.idx, e.per, e.pul, e.sz);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        tcyc++;
    endtask

    task automatic wait_cyc(input int n);
        while (tcyc < n) step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] p, input logic [31:0] pu,
                      input logic [7:0] s, input logic [15:0] r);
        cfg_we = 1'b1; cfg_addr = a; cfg_period = p; cfg_pulse = pu; cfg_size = s; cfg_repeat = r;
        step();
        cfg_we = 1'b0;
    endtask

    // Afterwards the bench sits in cycle 0 of the new sequence (tcyc = 0).
    task automatic go(input logic sp);
        start = 1'b1;
        stop  = sp;
        step();
        start = 1'b0;
        stop  = 1'b0;
        tcyc  = 0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    initial begin
        fork
            monitor();
        join_none

        #3;
        chk_all_zero("reset");
        step();
        step();
        PRESETn = 1'b1;
        step();

        wr(2'd0, 32'd3, 32'd2, 8'hFF, 16'd1);
        wr(2'd1, 32'd1, 32'd1, 8'h0F, 16'd0);
        last_idx = 2'd1;

        // Single-shot run
        loop = 1'b0;
        push(2'd0, 32'd3, 32'd2, 8'hFF, 8);
        push(2'd1, 32'd1, 32'd1, 8'h0F, 2);
        push_done(2'd1, 32'd1, 32'd1, 8'h0F);
        go(1'b0);
        wait_cyc(14);
        chk("single_idle_enable", enable, 32'd0);

        // Looping with a stop in the final period of entry 0: drains without loading entry 1
        loop = 1'b1;
        push(2'd0, 32'd3, 32'd2, 8'hFF, 8);
        push(2'd1, 32'd1, 32'd1, 8'h0F, 2);
        push(2'd0, 32'd3, 32'd2, 8'hFF, 8);
        push(2'd1, 32'd1, 32'd1, 8'h0F, 2);
        push(2'd0, 32'd3, 32'd2, 8'hFF, 8);
        push_done(2'd0, 32'd3, 32'd2, 8'hFF);
        go(1'b0);
        wait_cyc(25);
        pulse_stop();
        wait_cyc(32);
        loop = 1'b0;

        // start+stop together from idle starts; stop on a period-end cycle ends at once
        push(2'd0, 32'd3, 32'd2, 8'hFF, 4);
        push_done(2'd0, 32'd3, 32'd2, 8'hFF);
        go(1'b1);
        wait_cyc(3);
        pulse_stop();
        wait_cyc(8);
        chk("stop_pe_busy", {31'd0, busy}, 32'd0);

        // Rewrite entry 1 on the very edge it gets loaded
        loop = 1'b1;
        push(2'd0, 32'd3, 32'd2, 8'hFF, 8);
        push(2'd1, 32'd1, 32'd1, 8'h0F, 2);
        push(2'd0, 32'd3, 32'd2, 8'hFF, 8);
        push(2'd1, 32'd1, 32'd0, 8'h0F, 2);
        push_done(2'd1, 32'd1, 32'd0, 8'h0F);
        go(1'b0);
        wait_cyc(7);
        wr(2'd1, 32'd1, 32'd0, 8'h0F, 16'd0);
        wait_cyc(18);
        pulse_stop();
        wait_cyc(24);

        // Asynchronous reset in the middle of a period
        push(2'd0, 32'd3, 32'd2, 8'hFF, 2);
        go(1'b0);
        wait_cyc(2);
        #1;
        PRESETn = 1'b0;
        #1;
        chk_all_zero("async_reset");
        step();
        step();
        PRESETn = 1'b1;
        loop = 1'b0;
        step();

        // Cleared table: every entry is a 1-cycle period
        push(2'd0, 32'd0, 32'd0, 8'h00, 1);
        push(2'd1, 32'd0, 32'd0, 8'h00, 1);
        push_done(2'd1, 32'd0, 32'd0, 8'h00);
        go(1'b0);
        wait_cyc(6);

        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_sequencer.md
# pwm_sequencer

Programmable pattern sequencer driving the `period`/`pulse`/`size`/`enable` inputs of the 8-bit PWM core on the APB clock domain. Holds a small table of PWM settings, each with a repeat count, and steps through the table one PWM period at a time. Runs once or loops. Entries switch only at period boundaries, so the core never sees a truncated or mixed period. An internal counter mirrors the core's counter; no count feedback from the core is needed.

## Interface
Parameters:
- `DEPTH`, 4, number of table entries (2..16)
- `AW`, `$clog2(DEPTH)`, table index width

Ports:
- `PCLK` in 1: clock
- `PRESETn` in 1: reset, asynchronous, active-low
- `cfg_we` in 1: table write strobe
- `cfg_addr` in AW: table entry written
- `cfg_period` in 32: period field written
- `cfg_pulse` in 32: pulse field written
- `cfg_size` in 8: size field written
- `cfg_repeat` in 16: extra periods per entry
- `last_idx` in AW: index of final entry in the sequence
- `loop` in 1: level; 1 = wrap from `last_idx` back to entry 0
- `start` in 1: pulse; begin sequence at entry 0
- `stop` in 1: pulse; finish current period, then idle
- `period` out 32: to PWM core
- `pulse` out 32: to PWM core
- `size` out 32: to PWM core; bits [31:8] always 0
- `enable` out 32: to PWM core; only bit 0 used, [31:1] always 0
- `busy` out 1: high in RUN or DRAIN
- `idx` out AW: entry currently driving the core
- `done` out 1: one-cycle pulse on return to IDLE

## Operation
- Table: DEPTH entries of {period, pulse, size, repeat}, all flops.
  - Reset clears every entry to 0.
  - Write on `cfg_we` at any time, in any state.
  - Combinational read.
  - If a write and a load hit the same entry in the same cycle, the load captures the pre-write contents.
- Outputs `period`/`pulse`/`size` are shadow registers, loaded only on a load event. A write to the active entry takes effect the next time that entry is loaded.
- Mirror counter `cnt` (32b) and repeat counter `rep` (16b), both cleared on entry to RUN.
- Each entry runs `repeat`+1 periods. Each period lasts `period`+1 cycles (`period`=0 gives a 1-cycle period).
- FSM states: IDLE, RUN, DRAIN.
  - IDLE:
    - `enable[0]`=0.
    - `start` loads entry 0 into the outputs, sets `idx`=0 and `enable[0]`=1, clears `cnt` and `rep`, and goes to RUN.
    - `stop` is ignored, including when it arrives together with `start`.
  - RUN:
    - `cnt` increments every cycle.
    - Period end is the cycle where `cnt`==`period`. On that edge, `cnt`<=0.
    - If `rep`!=entry repeat: `rep`++.
    - Else `rep`<=0, and:
      - if `idx`!=`last_idx`: load entry `idx`+1;
      - else if `loop`: load entry 0;
      - else go to IDLE, `enable[0]`<=0, `done`=1.
    - `start` is ignored.
    - `stop` goes to DRAIN. `stop` wins over `start` in the same cycle.
  - DRAIN:
    - Counting continues as in RUN.
    - At the next period end: go to IDLE, `enable[0]`<=0, `done`=1. No load is performed.
    - If `stop` arrives at a period-end cycle in RUN, go directly to IDLE on that edge.
- `last_idx` and `loop` are sampled at each period end. `last_idx` ≥ DEPTH is treated as DEPTH-1.
- Reset values: all outputs 0; state IDLE; `idx`=0; `cnt`=0; `rep`=0; table cleared.

## Timing
- All outputs are registered. Reset mid-sequence forces all outputs to 0 asynchronously.
- Lock-step with the core: at a period-end edge, the core still compares against the old `period` and wraps to 0. The new `period`/`pulse`/`size` take effect from core count 0.
- Stopping: `enable[0]` falls on the same edge the core wraps to 0, so the core holds count 0 while idle. The next `start` therefore begins in sync.
- Start latency: `start` sampled at edge S; `enable[0]`=1 and outputs valid after S; core count reaches 1 at S+1.
- `done` is high for exactly the cycle following the final period-end edge. `busy` falls on that same edge.
- `idx` changes on the load edge, together with the outputs.

## Test plan
- Single-shot run.
  - Setup: entries 0/1 = {period 3, pulse 2, size 8'hFF, repeat 1} and {period 1, pulse 1, size 8'h0F, repeat 0}; `last_idx`=1; `loop`=0; `start`.
  - Required: entry 0 for 8 cycles (PWM FF,FF,00,00 ×2), then entry 1 for 2 cycles (0F,00), then `done` pulses and `enable`=0.
- Loop wrap.
  - Setup: same table with `loop`=1.
  - Required: `idx` sequence 0,1,0,1… with no gap cycle at the wrap; `done` never asserts.
- Stop mid-period.
  - Stimulus: `stop` at `cnt`=1 of entry 0.
  - Required: outputs unchanged until `cnt`=3; IDLE on that edge; `done`=1 for one cycle; no load of entry 1.
- Stop at period end, and `start`+`stop` together.
  - Stimulus: `stop` exactly at a period-end cycle.
  - Required: IDLE on that same edge.
  - Stimulus: `start` and `stop` together in IDLE.
  - Required: sequence starts.
- Write collision.
  - Stimulus: write entry 1 `pulse`=0 on the same cycle entry 1 is loaded.
  - Required: old `pulse` is driven for the current visit; the new value appears on the next visit.
- Async reset mid-RUN.
  - Stimulus: `PRESETn` low at `cnt`=2.
  - Required: all outputs 0 immediately.
  - Stimulus: after release, `start`.
  - Required: sequence restarts at entry 0 with table contents cleared (`period`=0, 1-cycle periods).
